// File: rtl/control_puertas_pkg.sv
// Shared types and encodings for the elevator door controller.
package control_puertas_pkg;

  typedef enum logic [2:0] {
    CERRADA  = 3'd0,
    ABRIENDO = 3'd1,
    ABIERTA  = 3'd2,
    CERRANDO = 3'd3,
    FALLA    = 3'd4
  } estado_t;

  localparam logic [1:0] NADA   = 2'b00;
  localparam logic [1:0] ABRIR  = 2'b01;
  localparam logic [1:0] CERRAR = 2'b10;

  localparam int BTN_ABRIR  = 1;
  localparam int BTN_CERRAR = 0;

  // Both timers share one width, wide enough for the larger of the two loads.
  function automatic int ancho_tmr(input int t_abierta, input int t_mov);
    return $clog2(((t_abierta > t_mov) ? t_abierta : t_mov) + 1);
  endfunction

endpackage

// File: rtl/control_puertas_n_temporizador.sv
// Load/decrement counter that saturates at zero and flags when empty.
module temporizador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cargar,
  input  logic         decrementar,
  input  logic [W-1:0] valor,
  output logic         cero
);

  logic [W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (cargar)
      cuenta_d = valor;
    else if (decrementar && (cuenta_q != '0))
      cuenta_d = cuenta_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cuenta_q <= '0;
    else       cuenta_q <= cuenta_d;
  end

  assign cero = (cuenta_q == '0);

endmodule

// File: rtl/control_puertas_n.sv
// Registered elevator door FSM: request matching, hold-open timer,
// reopen on obstruction and a motor watchdog with a latched fault.
module control_puertas_n
  import control_puertas_pkg::*;
#(
  parameter int N_PISOS   = 4,
  parameter int T_ABIERTA = 100,
  parameter int T_MOV     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(N_PISOS)-1:0] piso,
  input  logic                       direccion,
  input  logic                       detenido,
  input  logic [N_PISOS-1:0]         pedido_cabina,
  input  logic [N_PISOS-1:0]         pedido_subir,
  input  logic [N_PISOS-1:0]         pedido_bajar,
  input  logic [1:0]                 boton,
  input  logic                       fin_abierta,
  input  logic                       fin_cerrada,
  input  logic                       sensor,
  output logic [1:0]                 salida_puertas,
  output logic [N_PISOS-1:0]         aviso,
  output logic [N_PISOS-1:0]         limpiar_cabina,
  output logic [N_PISOS-1:0]         limpiar_subir,
  output logic [N_PISOS-1:0]         limpiar_bajar,
  output logic                       trabajando,
  output logic                       falla
);

  localparam int PW = $clog2(N_PISOS);
  localparam int TW = ancho_tmr(T_ABIERTA, T_MOV);
  localparam logic [TW-1:0] CARGA_ABIERTA = TW'(T_ABIERTA - 1);
  localparam logic [TW-1:0] CARGA_MOV     = TW'(T_MOV - 1);

  estado_t              estado_q, estado_d;
  logic [1:0]           salida_q, salida_d;
  logic [N_PISOS-1:0]   aviso_q, aviso_d, lc_q, lc_d, ls_q, ls_d, lb_q, lb_d;
  logic                 trab_q, trab_d, falla_q, falla_d;

  logic                 piso_ok, m_cab, m_sub, m_baj, servir, fines;
  logic [PW-1:0]        idx;
  logic [N_PISOS-1:0]   uno;
  logic                 hold_cargar, hold_dec, hold_cero;
  logic                 wd_cargar, wd_dec, wd_cero;

  temporizador #(.W(TW)) u_hold (
    .clk(clk), .reset(reset), .cargar(hold_cargar), .decrementar(hold_dec),
    .valor(CARGA_ABIERTA), .cero(hold_cero)
  );

  // Watchdog counts down from T_MOV-1; expiring at zero equals T_MOV cycles.
  temporizador #(.W(TW)) u_wd (
    .clk(clk), .reset(reset), .cargar(wd_cargar), .decrementar(wd_dec),
    .valor(CARGA_MOV), .cero(wd_cero)
  );

  always_comb begin
    piso_ok = (int'(piso) < N_PISOS);
    idx     = piso_ok ? piso : '0;
    uno     = {{(N_PISOS-1){1'b0}}, 1'b1} << idx;
    m_cab   = pedido_cabina[idx];
    m_sub   = pedido_subir[idx] && (!direccion || (idx == '0));
    m_baj   = pedido_bajar[idx] && (direccion || (int'(idx) == N_PISOS - 1));
    servir  = detenido && piso_ok && (m_cab || m_sub || m_baj);
    fines   = fin_abierta && fin_cerrada;
  end

  always_comb begin
    estado_d    = estado_q;
    hold_cargar = 1'b0;
    hold_dec    = 1'b0;
    wd_cargar   = 1'b0;
    wd_dec      = 1'b0;
    aviso_d     = '0;
    lc_d        = '0;
    ls_d        = '0;
    lb_d        = '0;
    case (estado_q)
      CERRADA: begin
        if (fines) estado_d = FALLA;
        else if (servir) begin
          estado_d  = ABRIENDO;
          wd_cargar = 1'b1;
          aviso_d   = uno;
          lc_d      = m_cab ? uno : '0;
          ls_d      = m_sub ? uno : '0;
          lb_d      = m_baj ? uno : '0;
        end else if (detenido && boton[BTN_ABRIR]) begin
          estado_d  = ABRIENDO;
          wd_cargar = 1'b1;
        end
      end
      ABRIENDO: begin
        if (fines) estado_d = FALLA;
        else if (fin_abierta) begin
          estado_d    = ABIERTA;
          hold_cargar = 1'b1;
        end else if (wd_cero) estado_d = FALLA;
        else wd_dec = 1'b1;
      end
      ABIERTA: begin
        if (fines) estado_d = FALLA;
        else if (sensor || boton[BTN_ABRIR]) hold_cargar = 1'b1;
        else if (boton[BTN_CERRAR] || hold_cero) begin
          estado_d  = CERRANDO;
          wd_cargar = 1'b1;
        end else hold_dec = 1'b1;
      end
      CERRANDO: begin
        if (fines) estado_d = FALLA;
        else if (sensor || boton[BTN_ABRIR]) begin
          estado_d  = ABRIENDO;
          wd_cargar = 1'b1;
        end else if (fin_cerrada) estado_d = CERRADA;
        else if (wd_cero) estado_d = FALLA;
        else wd_dec = 1'b1;
      end
      default: estado_d = FALLA;
    endcase

    salida_d = (estado_d == ABRIENDO) ? ABRIR :
               (estado_d == CERRANDO) ? CERRAR : NADA;
    trab_d   = (estado_d != CERRADA);
    falla_d  = (estado_d == FALLA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= CERRADA;
      salida_q <= NADA;
      aviso_q  <= '0;
      lc_q     <= '0;
      ls_q     <= '0;
      lb_q     <= '0;
      trab_q   <= 1'b0;
      falla_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      salida_q <= salida_d;
      aviso_q  <= aviso_d;
      lc_q     <= lc_d;
      ls_q     <= ls_d;
      lb_q     <= lb_d;
      trab_q   <= trab_d;
      falla_q  <= falla_d;
    end
  end

  assign salida_puertas = salida_q;
  assign aviso          = aviso_q;
  assign limpiar_cabina = lc_q;
  assign limpiar_subir  = ls_q;
  assign limpiar_bajar  = lb_q;
  assign trabajando     = trab_q;
  assign falla          = falla_q;

endmodule

// File: tb/tb_control_puertas_n.sv
// Directed bench for control_puertas_n with a queue of expected output sets.
module tb_control_puertas_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] piso;
  logic       direccion, detenido;
  logic [3:0] p_cab, p_sub, p_baj;
  logic [1:0] boton;
  logic       fin_abierta, fin_cerrada, sensor;
  logic [1:0] salida_puertas;
  logic [3:0] aviso, limpiar_cabina, limpiar_subir, limpiar_bajar;
  logic       trabajando, falla;

  localparam logic [1:0] NADA = 2'b00, ABRIR = 2'b01, CERRAR = 2'b10;

  control_puertas_n #(.N_PISOS(4), .T_ABIERTA(5), .T_MOV(3)) dut (
    .clk(clk), .reset(reset), .piso(piso), .direccion(direccion),
    .detenido(detenido), .pedido_cabina(p_cab), .pedido_subir(p_sub),
    .pedido_bajar(p_baj), .boton(boton), .fin_abierta(fin_abierta),
    .fin_cerrada(fin_cerrada), .sensor(sensor),
    .salida_puertas(salida_puertas), .aviso(aviso),
    .limpiar_cabina(limpiar_cabina), .limpiar_subir(limpiar_subir),
    .limpiar_bajar(limpiar_bajar), .trabajando(trabajando), .falla(falla)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sal;
    logic [3:0] av, lc, ls, lb;
    logic       tr, fa;
  } out_t;

  out_t  esp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic out_t muestra();
    out_t o;
    o.sal = salida_puertas; o.av = aviso; o.lc = limpiar_cabina;
    o.ls  = limpiar_subir;  o.lb = limpiar_bajar;
    o.tr  = trabajando;     o.fa = falla;
    return o;
  endfunction

  task automatic empuja(input string t, input logic [1:0] s, input logic [3:0] a,
                        input logic [3:0] lc, input logic [3:0] ls, input logic [3:0] lb,
                        input logic tr, input logic fa);
    out_t e;
    e.sal = s; e.av = a; e.lc = lc; e.ls = ls; e.lb = lb; e.tr = tr; e.fa = fa;
    esp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic compara();
    out_t  e, o;
    string t;
    e = esp_q.pop_front();
    t = tag_q.pop_front();
    o = muestra();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic c_abre(input string t, input logic [3:0] a, input logic [3:0] lc,
                        input logic [3:0] ls, input logic [3:0] lb);
    empuja(t, ABRIR, a, lc, ls, lb, 1'b1, 1'b0);
    @(posedge clk); #1;
    compara();
  endtask

  task automatic c_est(input string t, input logic [1:0] s, input logic tr, input logic fa);
    empuja(t, s, 4'b0, 4'b0, 4'b0, 4'b0, tr, fa);
    @(posedge clk); #1;
    compara();
  endtask

  task automatic chk_reset(input string t);
    empuja(t, NADA, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    #1;
    compara();
  endtask

  initial begin
    reset = 1'b1; piso = 2'd0; direccion = 1'b0; detenido = 1'b0;
    p_cab = '0; p_sub = '0; p_baj = '0; boton = '0;
    fin_abierta = 1'b0; fin_cerrada = 1'b0; sensor = 1'b0;
    #2 chk_reset("reset_inicial");
    @(negedge clk) reset = 1'b0;

    // basic cycle
    piso = 2'd2; direccion = 1'b0; detenido = 1'b1; p_sub = 4'b0100;
    c_abre("t1_abre", 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    p_sub = '0; fin_abierta = 1'b1;
    c_est("t1_abierta1", NADA, 1'b1, 1'b0);
    repeat (4) c_est("t1_abierta", NADA, 1'b1, 1'b0);
    fin_abierta = 1'b0;
    c_est("t1_cierra", CERRAR, 1'b1, 1'b0);
    fin_cerrada = 1'b1;
    c_est("t1_cerrada", NADA, 1'b0, 1'b0);
    c_est("t1_reposo", NADA, 1'b0, 1'b0);
    fin_cerrada = 1'b0;

    // direction matching and close button
    p_baj = 4'b0100;
    c_est("t2_bajar_no", NADA, 1'b0, 1'b0);
    piso = 2'd3; p_baj = 4'b1000;
    c_abre("t2_tope", 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    p_baj = '0; fin_abierta = 1'b1;
    c_est("t2_abierta", NADA, 1'b1, 1'b0);
    c_est("t2_abierta2", NADA, 1'b1, 1'b0);
    boton = 2'b01;
    c_est("t4_cerrar_btn", CERRAR, 1'b1, 1'b0);
    boton = '0; fin_abierta = 1'b0; fin_cerrada = 1'b1;
    c_est("t2_cerrada", NADA, 1'b0, 1'b0);
    fin_cerrada = 1'b0; detenido = 1'b0; piso = 2'd2; p_cab = 4'b0100; p_sub = 4'b0100;
    c_est("t2_detenido0", NADA, 1'b0, 1'b0);
    detenido = 1'b1;
    c_abre("t2_cabina", 4'b0100, 4'b0100, 4'b0100, 4'b0000);

    // open button reloads the hold timer
    p_cab = '0; p_sub = '0; fin_abierta = 1'b1;
    c_est("t4_abierta", NADA, 1'b1, 1'b0);
    boton = 2'b11;
    c_est("t4_btn11a", NADA, 1'b1, 1'b0);
    c_est("t4_btn11b", NADA, 1'b1, 1'b0);
    boton = '0;
    repeat (4) c_est("t4_recarga", NADA, 1'b1, 1'b0);
    fin_abierta = 1'b0;
    c_est("t4_cierra", CERRAR, 1'b1, 1'b0);

    // reopen restarts the watchdog and issues no pulses
    c_est("t3_cerrando", CERRAR, 1'b1, 1'b0);
    sensor = 1'b1; p_cab = 4'b0100;
    c_abre("t3_reabre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    sensor = 1'b0; p_cab = '0;
    c_est("t3_abriendo2", ABRIR, 1'b1, 1'b0);
    c_est("t3_abriendo3", ABRIR, 1'b1, 1'b0);
    fin_abierta = 1'b1;
    c_est("t3_abierta", NADA, 1'b1, 1'b0);

    // both limit switches
    fin_cerrada = 1'b1;
    c_est("t6_dos_fines", NADA, 1'b1, 1'b1);
    fin_abierta = 1'b0; fin_cerrada = 1'b0;
    c_est("t6_falla_fija", NADA, 1'b1, 1'b1);
    reset = 1'b1;
    chk_reset("t6_reset_falla");
    reset = 1'b0;
    c_est("t6_tras_reset", NADA, 1'b0, 1'b0);

    // ground floor up request while travelling down
    direccion = 1'b1; p_sub = 4'b0100;
    c_est("t2_subir_dir1_no", NADA, 1'b0, 1'b0);
    piso = 2'd0; p_sub = 4'b0001;
    c_abre("t2_planta0", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    p_sub = '0; reset = 1'b1;
    chk_reset("t2_reset_abriendo");
    reset = 1'b0;

    // watchdog while opening
    direccion = 1'b0; piso = 2'd1; p_cab = 4'b0010;
    c_abre("t5_abre", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    p_cab = '0;
    c_est("t5_abr2", ABRIR, 1'b1, 1'b0);
    c_est("t5_abr3", ABRIR, 1'b1, 1'b0);
    c_est("t5_falla", NADA, 1'b1, 1'b1);
    repeat (2) c_est("t5_falla_fija", NADA, 1'b1, 1'b1);
    reset = 1'b1;
    chk_reset("t5_reset");
    reset = 1'b0;

    // button open without request, then reset mid-close
    boton = 2'b10;
    c_abre("t6_boton_abre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    boton = '0; fin_abierta = 1'b1;
    c_est("t6_abierta", NADA, 1'b1, 1'b0);
    boton = 2'b01;
    c_est("t6_cerrando", CERRAR, 1'b1, 1'b0);
    boton = '0; fin_abierta = 1'b0;
    #2 reset = 1'b1;
    chk_reset("t6_reset_cerrando");
    reset = 1'b0;
    c_est("t6_cerrada", NADA, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
